// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the ALU-sharing arbiter:
//   - sequencer state encoding (IDLE -> EXEC -> RESP -> IDLE)
//   - ALU function codes used by requesters and benches
//   - default datapath width and a helper for requester-index width
// No ports (package).
// -----------------------------------------------------------------------------
package alu_arb_pkg;

   localparam int ALU_DW_DEFAULT = 32;

   // Function codes understood by the ALU stage. The arbiter never decodes
   // them; they exist so requesters and benches agree on the encoding.
   localparam logic [3:0] FUNC_ADD = 4'b0000;
   localparam logic [3:0] FUNC_OR  = 4'b0011;
   localparam logic [3:0] FUNC_NOT = 4'b0100;
   localparam logic [3:0] FUNC_ROR = 4'b1101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Width of a requester index; never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin winner selection. The search starts at
// the requester after last_grant and wraps around, so the most recent winner
// has the lowest priority on the next arbitration.
//
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  IW       index of the most recently granted requester
//   grant      out NUM_REQ  one-hot winner (all zero when no request)
//   grant_id   out IW       binary index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IW      = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      grant_id
);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      // NOTE: every variable gets a default before the search loop, so no
      // path through the block leaves one unassigned and no latch is inferred.
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = '0;
      // Offset 1 visits the requester just after the last winner first;
      // offset NUM_REQ revisits the last winner itself, so it only wins when
      // nobody else is asking.
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = IW'((int'(last_grant) + off) % NUM_REQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = idx;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU stage between NUM_REQ requesters. A request is
// accepted in IDLE, its operands are registered onto the ALU stage inputs,
// the ALU result is captured one cycle later and returned over a per-requester
// valid/ready response channel. Only one request is in flight at a time.
//
// Ports:
//   Clk          in  1           clock, all state on rising edge
//   Rst_n        in  1           asynchronous active-low reset
//   Req_valid    in  NUM_REQ     per-requester request valid
//   Req_ready    out NUM_REQ     one-hot accept strobe (IDLE only)
//   Req_A        in  NUM_REQ*DW  RF_A operands, requester i at [i*DW +: DW]
//   Req_B        in  NUM_REQ*DW  RF_B operands
//   Req_Immed    in  NUM_REQ*DW  immediates
//   Req_func     in  NUM_REQ*4   ALU function codes, requester i at [i*4 +: 4]
//   Req_Bin_sel  in  NUM_REQ     B-input select (1 = Immed)
//   Rsp_valid    out NUM_REQ     one-hot response valid
//   Rsp_ready    in  NUM_REQ     per-requester response ready
//   Rsp_data     out DW          result, shared by all requesters
//   Busy         out 1           high whenever a request is in flight
//   ALU_RF_A     out DW          to ALU stage
//   ALU_RF_B     out DW          to ALU stage
//   ALU_Immed    out DW          to ALU stage
//   ALU_func     out 4           to ALU stage
//   ALU_Bin_sel  out 1           to ALU stage
//   ALU_out      in  DW          from ALU stage (combinational)
// -----------------------------------------------------------------------------
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DW      = ALU_DW_DEFAULT
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic [NUM_REQ-1:0]    Req_valid,
   output logic [NUM_REQ-1:0]    Req_ready,
   input  logic [NUM_REQ*DW-1:0] Req_A,
   input  logic [NUM_REQ*DW-1:0] Req_B,
   input  logic [NUM_REQ*DW-1:0] Req_Immed,
   input  logic [NUM_REQ*4-1:0]  Req_func,
   input  logic [NUM_REQ-1:0]    Req_Bin_sel,
   output logic [NUM_REQ-1:0]    Rsp_valid,
   input  logic [NUM_REQ-1:0]    Rsp_ready,
   output logic [DW-1:0]         Rsp_data,
   output logic                  Busy,
   output logic [DW-1:0]         ALU_RF_A,
   output logic [DW-1:0]         ALU_RF_B,
   output logic [DW-1:0]         ALU_Immed,
   output logic [3:0]            ALU_func,
   output logic                  ALU_Bin_sel,
   input  logic [DW-1:0]         ALU_out
);

   localparam int IW = idx_width(NUM_REQ);

   state_e               state;
   state_e               state_next;
   logic [IW-1:0]        last_grant;
   logic [IW-1:0]        id;
   logic [NUM_REQ-1:0]   grant;
   logic [IW-1:0]        grant_id;
   logic [NUM_REQ-1:0]   id_onehot;
   logic                 accept;
   logic                 rsp_done;

   // ---------------------------------------------------------------------------
   // Arbitration. The arbiter runs every cycle, but its grant is only exposed
   // as Req_ready in IDLE; gating with Rst_n keeps Req_ready low throughout
   // reset even though the arbiter itself sees live requests.
   // ---------------------------------------------------------------------------
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr_arbiter (
      .req        (Req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_id   (grant_id)
   );

   assign Req_ready = (state == IDLE && Rst_n) ? grant : '0;
   assign accept    = |(Req_valid & Req_ready);
   // Only the owner of the in-flight request can complete the response.
   assign rsp_done  = (state == RESP) && Rsp_ready[id];
   assign Busy      = (state != IDLE);

   always_comb begin
      id_onehot     = '0;
      id_onehot[id] = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Sequencer FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Rst_n) begin
      // NOTE: registers use non-blocking assignments so every flop samples the
      // values from before the edge, independent of statement order.
      if (!Rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)   state_next = EXEC;
         EXEC:                  state_next = RESP;
         RESP:    if (rsp_done) state_next = IDLE;
         default:               state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Operand registers and response path. The ALU_* registers only load on
   // accept, so the ALU stage sees stable inputs for the whole EXEC cycle and
   // keeps the last operands in RESP and IDLE.
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ALU_RF_A    <= '0;
         ALU_RF_B    <= '0;
         ALU_Immed   <= '0;
         ALU_func    <= '0;
         ALU_Bin_sel <= 1'b0;
         id          <= '0;
         last_grant  <= IW'(NUM_REQ - 1);
         Rsp_data    <= '0;
         Rsp_valid   <= '0;
      end else begin
         if (accept) begin
            ALU_RF_A    <= Req_A[int'(grant_id)*DW +: DW];
            ALU_RF_B    <= Req_B[int'(grant_id)*DW +: DW];
            ALU_Immed   <= Req_Immed[int'(grant_id)*DW +: DW];
            ALU_func    <= Req_func[int'(grant_id)*4 +: 4];
            ALU_Bin_sel <= Req_Bin_sel[grant_id];
            id          <= grant_id;
            last_grant  <= grant_id;
         end

         if (state == EXEC) begin
            Rsp_data  <= ALU_out;
            Rsp_valid <= id_onehot;
         end

         if (rsp_done) begin
            Rsp_valid <= '0;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Self-checking bench for alu_share_arbiter with NUM_REQ=2, DW=32. A behavioural
// ALU stage closes the loop on the ALU_* nets. Expected responses are pushed
// to a scoreboard queue when a request is enqueued and compared in order
// against the responses the DUT produces.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;
   import alu_arb_pkg::*;

   localparam int N  = 2;
   localparam int DW = 32;

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] imm;
      logic [3:0]    func;
      logic          bsel;
   } req_t;

   typedef struct {
      logic [N-1:0]  vld;
      logic [DW-1:0] data;
   } rsp_t;

   logic            Clk;
   logic            Rst_n;
   logic [N-1:0]    Req_valid;
   logic [N-1:0]    Req_ready;
   logic [N*DW-1:0] Req_A;
   logic [N*DW-1:0] Req_B;
   logic [N*DW-1:0] Req_Immed;
   logic [N*4-1:0]  Req_func;
   logic [N-1:0]    Req_Bin_sel;
   logic [N-1:0]    Rsp_valid;
   logic [N-1:0]    Rsp_ready;
   logic [DW-1:0]   Rsp_data;
   logic            Busy;
   logic [DW-1:0]   ALU_RF_A;
   logic [DW-1:0]   ALU_RF_B;
   logic [DW-1:0]   ALU_Immed;
   logic [3:0]      ALU_func;
   logic            ALU_Bin_sel;
   logic [DW-1:0]   ALU_out;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic prev_rsp = 1'b0;

   req_t pend [N][$];
   rsp_t exp_q[$];
   rsp_t rsp_log[$];
   int   acc_id[$];
   int   acc_cyc[$];

   alu_share_arbiter #(.NUM_REQ(N), .DW(DW)) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .Req_valid   (Req_valid),
      .Req_ready   (Req_ready),
      .Req_A       (Req_A),
      .Req_B       (Req_B),
      .Req_Immed   (Req_Immed),
      .Req_func    (Req_func),
      .Req_Bin_sel (Req_Bin_sel),
      .Rsp_valid   (Rsp_valid),
      .Rsp_ready   (Rsp_ready),
      .Rsp_data    (Rsp_data),
      .Busy        (Busy),
      .ALU_RF_A    (ALU_RF_A),
      .ALU_RF_B    (ALU_RF_B),
      .ALU_Immed   (ALU_Immed),
      .ALU_func    (ALU_func),
      .ALU_Bin_sel (ALU_Bin_sel),
      .ALU_out     (ALU_out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Behavioural ALU stage; unknown codes produce A ^ B.
   function automatic logic [DW-1:0] alu_model(input logic [3:0] f,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (f)
         FUNC_ADD: return a + b;
         FUNC_OR:  return a | b;
         FUNC_NOT: return ~a;
         FUNC_ROR: return (sh == 5'd0) ? a : ((a >> sh) | (a << (6'd32 - {1'b0, sh})));
         default:  return a ^ b;
      endcase
   endfunction

   always_comb ALU_out = alu_model(ALU_func, ALU_RF_A, ALU_Bin_sel ? ALU_Immed : ALU_RF_B);

   // Put the head of requester i's pending list on its request bus.
   task automatic apply(input int i);
      Req_A[i*DW +: DW]     = pend[i][0].a;
      Req_B[i*DW +: DW]     = pend[i][0].b;
      Req_Immed[i*DW +: DW] = pend[i][0].imm;
      Req_func[i*4 +: 4]    = pend[i][0].func;
      Req_Bin_sel[i]        = pend[i][0].bsel;
      Req_valid[i]          = 1'b1;
   endtask

   // Queue a request for requester i and push its expected response.
   task automatic enqueue(input int i, input req_t r);
      rsp_t e;
      pend[i].push_back(r);
      e.vld  = N'(1) << i;
      e.data = alu_model(r.func, r.a, r.bsel ? r.imm : r.b);
      exp_q.push_back(e);
      if (pend[i].size() == 1) apply(i);
   endtask

   // One clock: record accepts seen before the edge, advance requesters past
   // accepted items, and log each newly raised response.
   task automatic tick();
      logic [N-1:0] acc;
      rsp_t r;
      acc = Req_valid & Req_ready;
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            acc_id.push_back(i);
            acc_cyc.push_back(cyc);
            pend[i].delete(0);
            if (pend[i].size() > 0) apply(i);
            else Req_valid[i] = 1'b0;
         end
      end
      if ((Rsp_valid != '0) && !prev_rsp) begin
         r.vld  = Rsp_valid;
         r.data = Rsp_data;
         rsp_log.push_back(r);
      end
      prev_rsp = |Rsp_valid;
      #1;
   endtask

   task automatic flush_bench();
      Req_valid = '0;
      for (int i = 0; i < N; i++) pend[i].delete();
      exp_q.delete();
      rsp_log.delete();
      acc_id.delete();
      acc_cyc.delete();
      prev_rsp = 1'b0;
      cyc      = 0;
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      flush_bench();
      @(negedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      #1;
   endtask

   // Run until all queued requests are accepted and answered, bounded.
   task automatic drain(input int max_cyc, input string name);
      int n;
      n = 0;
      while ((pend[0].size() > 0 || pend[1].size() > 0 || Busy) && n < max_cyc) begin
         tick();
         n++;
      end
      checks++;
      if (n >= max_cyc) begin
         errors++;
         $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      Rst_n     = 1'b0;
      Req_valid = '1;
      #1;
      checks++; if (Req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b required 00", Req_ready); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", Busy); end
      checks++; if (Rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b required 00", Rsp_valid); end
      checks++; if (Rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h required 0", Rsp_data); end
      checks++;
      if ({ALU_RF_A, ALU_RF_B, ALU_Immed, ALU_func, ALU_Bin_sel} !== '0) begin
         errors++;
         $display("FAIL reset_alu_regs: got A=%h B=%h I=%h f=%h s=%b required all 0",
                  ALU_RF_A, ALU_RF_B, ALU_Immed, ALU_func, ALU_Bin_sel);
      end
      Req_valid = '0;
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      Rsp_ready = '1;
      enqueue(0, '{32'd1, 32'd4, 32'd12, FUNC_ADD, 1'b0});
      #1;
      checks++; if (Req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready: got %b required 01", Req_ready); end
      tick();
      checks++; if (ALU_RF_A !== 32'd1) begin errors++; $display("FAIL single_alu_a: got %h required 1", ALU_RF_A); end
      checks++; if (ALU_RF_B !== 32'd4) begin errors++; $display("FAIL single_alu_b: got %h required 4", ALU_RF_B); end
      checks++; if (ALU_Immed !== 32'd12) begin errors++; $display("FAIL single_alu_immed: got %h required c", ALU_Immed); end
      checks++; if (ALU_func !== FUNC_ADD || ALU_Bin_sel !== 1'b0) begin errors++; $display("FAIL single_alu_func: got %h/%b required 0/0", ALU_func, ALU_Bin_sel); end
      checks++; if (Busy !== 1'b1 || Req_ready !== 2'b00) begin errors++; $display("FAIL single_exec: got busy=%b ready=%b required 1/00", Busy, Req_ready); end
      tick();
      checks++; if (Rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b required 01", Rsp_valid); end
      checks++; if (Rsp_data !== 32'd5) begin errors++; $display("FAIL single_rsp_data: got %h required 5", Rsp_data); end
      tick();
      checks++; if (Busy !== 1'b0 || Rsp_valid !== 2'b00) begin errors++; $display("FAIL single_idle: got busy=%b valid=%b required 0/00", Busy, Rsp_valid); end
      checks++; if (rsp_log.size() !== exp_q.size()) begin errors++; $display("FAIL single_rsp_count: got %0d required %0d", rsp_log.size(), exp_q.size()); end
      while (exp_q.size() > 0 && rsp_log.size() > 0) begin
         rsp_t e, r;
         e = exp_q.pop_front();
         r = rsp_log.pop_front();
         checks++;
         if (r.vld !== e.vld || r.data !== e.data) begin
            errors++;
            $display("FAIL single_sb: got %b/%h required %b/%h", r.vld, r.data, e.vld, e.data);
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      Rsp_ready = '1;
      enqueue(0, '{32'd1, 32'd0, 32'd12, FUNC_ADD, 1'b1});
      enqueue(1, '{32'd1, 32'd0, 32'd12, FUNC_OR,  1'b1});
      #1;
      checks++; if (Req_ready !== 2'b01) begin errors++; $display("FAIL simul_first_ready: got %b required 01", Req_ready); end
      drain(20, "simul");
      checks++;
      if (acc_id.size() != 2) begin
         errors++;
         $display("FAIL simul_accepts: got %0d accepts required 2", acc_id.size());
      end else begin
         if (acc_id[0] != 0 || acc_id[1] != 1) begin
            errors++;
            $display("FAIL simul_order: got %0d,%0d required 0,1", acc_id[0], acc_id[1]);
         end
         checks++;
         if (acc_cyc[1] - acc_cyc[0] != 3) begin
            errors++;
            $display("FAIL simul_spacing: got %0d cycles required 3", acc_cyc[1] - acc_cyc[0]);
         end
      end
      checks++; if (rsp_log.size() !== exp_q.size()) begin errors++; $display("FAIL simul_rsp_count: got %0d required %0d", rsp_log.size(), exp_q.size()); end
      while (exp_q.size() > 0 && rsp_log.size() > 0) begin
         rsp_t e, r;
         e = exp_q.pop_front();
         r = rsp_log.pop_front();
         checks++;
         if (r.vld !== e.vld || r.data !== e.data) begin
            errors++;
            $display("FAIL simul_sb: got %b/%h required %b/%h", r.vld, r.data, e.vld, e.data);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      Rsp_ready = 2'b00;
      enqueue(1, '{32'd1, 32'd0, 32'd0, FUNC_NOT, 1'b0});
      #1;
      for (int n = 0; n < 10 && Rsp_valid == '0; n++) tick();
      checks++; if (Rsp_valid === '0) begin errors++; $display("FAIL bp_rsp_timeout: got no response required 10"); end
      // Requester 0 asks meanwhile; non-owner ready must be ignored.
      enqueue(0, '{32'd2, 32'd3, 32'd0, FUNC_ADD, 1'b0});
      Rsp_ready[0] = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         checks++; if (Rsp_valid !== 2'b10) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b required 10", k, Rsp_valid); end
         checks++; if (Rsp_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h required fffffffe", k, Rsp_data); end
         checks++; if (Busy !== 1'b1 || Req_ready !== 2'b00) begin errors++; $display("FAIL bp_hold_busy[%0d]: got busy=%b ready=%b required 1/00", k, Busy, Req_ready); end
         tick();
      end
      Rsp_ready[1] = 1'b1;
      tick();
      checks++; if (Rsp_valid !== 2'b00 || Busy !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b busy=%b required 00/0", Rsp_valid, Busy); end
      checks++; if (Req_ready !== 2'b01) begin errors++; $display("FAIL bp_next_ready: got %b required 01", Req_ready); end
      drain(20, "bp");
      checks++; if (rsp_log.size() !== exp_q.size()) begin errors++; $display("FAIL bp_rsp_count: got %0d required %0d", rsp_log.size(), exp_q.size()); end
      while (exp_q.size() > 0 && rsp_log.size() > 0) begin
         rsp_t e, r;
         e = exp_q.pop_front();
         r = rsp_log.pop_front();
         checks++;
         if (r.vld !== e.vld || r.data !== e.data) begin
            errors++;
            $display("FAIL bp_sb: got %b/%h required %b/%h", r.vld, r.data, e.vld, e.data);
         end
      end
   endtask

   task automatic test_fairness();
      do_reset();
      Rsp_ready = '1;
      enqueue(0, '{32'd3,   32'd4, 32'd0,      FUNC_ADD, 1'b0});
      enqueue(1, '{32'd5,   32'd0, 32'd10,     FUNC_OR,  1'b1});
      enqueue(0, '{32'd1,   32'd1, 32'd0,      FUNC_ROR, 1'b0});
      enqueue(1, '{32'd1,   32'd0, 32'h100,    FUNC_ADD, 1'b1});
      enqueue(0, '{32'd0,   32'd0, 32'd0,      FUNC_NOT, 1'b0});
      enqueue(1, '{32'h10,  32'd0, 32'd4,      FUNC_ROR, 1'b1});
      #1;
      drain(60, "fair");
      checks++;
      if (acc_id.size() != 6) begin
         errors++;
         $display("FAIL fair_accepts: got %0d accepts required 6", acc_id.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            if (k > 0) checks++;
            if (acc_id[k] != k % 2) begin
               errors++;
               $display("FAIL fair_order[%0d]: got %0d required %0d", k, acc_id[k], k % 2);
            end
         end
      end
      checks++;
      if (rsp_log.size() < 3 || rsp_log[2].data !== 32'h8000_0000) begin
         errors++;
         $display("FAIL fair_ror: got %h required 80000000", (rsp_log.size() < 3) ? 32'hx : rsp_log[2].data);
      end
      checks++; if (rsp_log.size() !== exp_q.size()) begin errors++; $display("FAIL fair_rsp_count: got %0d required %0d", rsp_log.size(), exp_q.size()); end
      while (exp_q.size() > 0 && rsp_log.size() > 0) begin
         rsp_t e, r;
         e = exp_q.pop_front();
         r = rsp_log.pop_front();
         checks++;
         if (r.vld !== e.vld || r.data !== e.data) begin
            errors++;
            $display("FAIL fair_sb: got %b/%h required %b/%h", r.vld, r.data, e.vld, e.data);
         end
      end
   endtask

   task automatic test_func_passthrough();
      do_reset();
      Rsp_ready = '1;
      enqueue(1, '{32'd7, 32'd9, 32'h55, 4'b1010, 1'b1});
      #1;
      tick();
      checks++; if (ALU_func !== 4'b1010 || ALU_Bin_sel !== 1'b1) begin errors++; $display("FAIL func_pass: got %b/%b required 1010/1", ALU_func, ALU_Bin_sel); end
      checks++; if (ALU_RF_A !== 32'd7 || ALU_Immed !== 32'h55) begin errors++; $display("FAIL func_operands: got %h/%h required 7/55", ALU_RF_A, ALU_Immed); end
      drain(20, "func");
      checks++; if (rsp_log.size() !== exp_q.size()) begin errors++; $display("FAIL func_rsp_count: got %0d required %0d", rsp_log.size(), exp_q.size()); end
      while (exp_q.size() > 0 && rsp_log.size() > 0) begin
         rsp_t e, r;
         e = exp_q.pop_front();
         r = rsp_log.pop_front();
         checks++;
         if (r.vld !== e.vld || r.data !== e.data) begin
            errors++;
            $display("FAIL func_sb: got %b/%h required %b/%h", r.vld, r.data, e.vld, e.data);
         end
      end
   endtask

   task automatic test_reset_mid_exec();
      do_reset();
      Rsp_ready = '1;
      enqueue(0, '{32'd1, 32'd4, 32'd12, FUNC_ADD, 1'b0});
      #1;
      tick();
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL midrst_in_exec: got busy=%b required 1", Busy); end
      Rst_n = 1'b0;
      #1;
      checks++; if (Busy !== 1'b0 || Rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_async: got busy=%b valid=%b required 0/00", Busy, Rsp_valid); end
      checks++;
      if ({ALU_RF_A, ALU_RF_B, ALU_Immed, ALU_func, ALU_Bin_sel} !== '0) begin
         errors++;
         $display("FAIL midrst_alu: got A=%h B=%h I=%h f=%h required all 0", ALU_RF_A, ALU_RF_B, ALU_Immed, ALU_func);
      end
      flush_bench();
      @(posedge Clk);
      @(negedge Clk);
      checks++; if (Rsp_valid !== 2'b00 || Rsp_data !== 32'h0) begin errors++; $display("FAIL midrst_no_rsp: got %b/%h required 00/0", Rsp_valid, Rsp_data); end
      Rst_n = 1'b1;
      #1;
      enqueue(0, '{32'd8, 32'd0, 32'd1, FUNC_ROR, 1'b1});
      enqueue(1, '{32'd6, 32'd1, 32'd0, FUNC_OR,  1'b0});
      #1;
      checks++; if (Req_ready !== 2'b01) begin errors++; $display("FAIL midrst_winner: got %b required 01", Req_ready); end
      drain(20, "midrst");
      checks++; if (rsp_log.size() !== exp_q.size()) begin errors++; $display("FAIL midrst_rsp_count: got %0d required %0d", rsp_log.size(), exp_q.size()); end
      while (exp_q.size() > 0 && rsp_log.size() > 0) begin
         rsp_t e, r;
         e = exp_q.pop_front();
         r = rsp_log.pop_front();
         checks++;
         if (r.vld !== e.vld || r.data !== e.data) begin
            errors++;
            $display("FAIL midrst_sb: got %b/%h required %b/%h", r.vld, r.data, e.vld, e.data);
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   initial begin
      Rst_n       = 1'b0;
      Req_valid   = '0;
      Req_A       = '0;
      Req_B       = '0;
      Req_Immed   = '0;
      Req_func    = '0;
      Req_Bin_sel = '0;
      Rsp_ready   = '0;
      @(negedge Clk);
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_fairness();
      test_func_passthrough();
      test_reset_mid_exec();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
